rvfi_insn_checker: RTL

Sequential checker that sits directly downstream of an `rvfi_insn_*` instruction-spec module. It captures one qualifying retirement from the core's RVFI port together with the spec module's `spec_*` outputs, compares them field by field, and reports a sticky pass/fail verdict. A mismatch bitmask records which fields disagreed, and a retirement counter and timeout guard against a check that never fires.

---
 rtl/rvfi_insn_checker.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rvfi_insn_checker.sv
// rtl/rvfi_insn_checker.sv - captures one RVFI retirement and checks it against an rvfi_insn_* spec module
// Sticky pass/fail verdict with a per-field mismatch mask, retirement counter and timeout.
module rvfi_insn_checker #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              rvfi_valid,
  input  logic              rvfi_trap,
  input  logic [4:0]        rvfi_rd_addr,
  input  logic [XLEN-1:0]   rvfi_rd_wdata,
  input  logic [XLEN-1:0]   rvfi_pc_wdata,
  input  logic [XLEN-1:0]   rvfi_mem_addr,
  input  logic [XLEN-1:0]   rvfi_mem_wdata,
  input  logic [XLEN/8-1:0] rvfi_mem_wmask,
  input  logic              spec_valid,
  input  logic              spec_trap,
  input  logic [4:0]        spec_rd_addr,
  input  logic [XLEN-1:0]   spec_rd_wdata,
  input  logic [XLEN-1:0]   spec_pc_wdata,
  input  logic [XLEN-1:0]   spec_mem_addr,
  input  logic [XLEN-1:0]   spec_mem_wdata,
  input  logic [XLEN/8-1:0] spec_mem_wmask,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [7:0]        fail_code,
  output logic [15:0]       retire_count
);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_CAPT, S_PASS, S_FAIL} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t state, state_next;
  logic [15:0] tmo_cnt;
  logic        qualify;
  logic [7:0]  cmp_code;
  logic [XLEN-1:0] lane_bits;

  logic              c_rvfi_trap, c_spec_trap;
  logic [4:0]        c_rvfi_rd_addr, c_spec_rd_addr;
  logic [XLEN-1:0]   c_rvfi_rd_wdata, c_spec_rd_wdata;
  logic [XLEN-1:0]   c_rvfi_pc_wdata, c_spec_pc_wdata;
  logic [XLEN-1:0]   c_rvfi_mem_addr, c_spec_mem_addr;
  logic [XLEN-1:0]   c_rvfi_mem_wdata, c_spec_mem_wdata;
  logic [XLEN/8-1:0] c_rvfi_mem_wmask, c_spec_mem_wmask;

  assign qualify = rvfi_valid && spec_valid;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_ARMED;
      S_ARMED: begin
        if (qualify)                  state_next = S_CAPT;
        else if (tmo_cnt == TMO_LAST) state_next = S_FAIL;
      end
      S_CAPT:  state_next = (cmp_code == 8'h00) ? S_PASS : S_FAIL;
      S_PASS:  if (start) state_next = S_ARMED;
      S_FAIL:  if (start) state_next = S_ARMED;
      default: state_next = S_IDLE;
    endcase
  end

  // Write data is only meaningful on lanes the spec says are written.
  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < XLEN/8; i++) lane_bits[i*8 +: 8] = {8{c_spec_mem_wmask[i]}};
  end

  always_comb begin
    cmp_code = 8'h00;
    cmp_code[0] = c_spec_trap != c_rvfi_trap;
    if (!c_spec_trap) begin
      cmp_code[1] = c_spec_rd_addr  != c_rvfi_rd_addr;
      cmp_code[2] = c_spec_rd_wdata != c_rvfi_rd_wdata;
      cmp_code[3] = c_spec_pc_wdata != c_rvfi_pc_wdata;
      cmp_code[4] = c_spec_mem_wmask != c_rvfi_mem_wmask;
      cmp_code[5] = (c_spec_mem_wmask != '0) && (c_spec_mem_addr != c_rvfi_mem_addr);
      cmp_code[6] = ((c_spec_mem_wdata ^ c_rvfi_mem_wdata) & lane_bits) != '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt          <= '0;
      fail_code        <= '0;
      retire_count     <= '0;
      c_rvfi_trap      <= 1'b0;
      c_spec_trap      <= 1'b0;
      c_rvfi_rd_addr   <= '0;
      c_spec_rd_addr   <= '0;
      c_rvfi_rd_wdata  <= '0;
      c_spec_rd_wdata  <= '0;
      c_rvfi_pc_wdata  <= '0;
      c_spec_pc_wdata  <= '0;
      c_rvfi_mem_addr  <= '0;
      c_spec_mem_addr  <= '0;
      c_rvfi_mem_wdata <= '0;
      c_spec_mem_wdata <= '0;
      c_rvfi_mem_wmask <= '0;
      c_spec_mem_wmask <= '0;
    end else begin
      case (state)
        S_IDLE, S_PASS, S_FAIL: begin
          if (start) begin
            tmo_cnt      <= '0;
            fail_code    <= '0;
            retire_count <= '0;
          end
        end
        S_ARMED: begin
          if (rvfi_valid && retire_count != 16'hFFFF) retire_count <= retire_count + 16'd1;
          if (qualify) begin
            c_rvfi_trap      <= rvfi_trap;
            c_spec_trap      <= spec_trap;
            c_rvfi_rd_addr   <= rvfi_rd_addr;
            c_spec_rd_addr   <= spec_rd_addr;
            c_rvfi_rd_wdata  <= rvfi_rd_wdata;
            c_spec_rd_wdata  <= spec_rd_wdata;
            c_rvfi_pc_wdata  <= rvfi_pc_wdata;
            c_spec_pc_wdata  <= spec_pc_wdata;
            c_rvfi_mem_addr  <= rvfi_mem_addr;
            c_spec_mem_addr  <= spec_mem_addr;
            c_rvfi_mem_wdata <= rvfi_mem_wdata;
            c_spec_mem_wdata <= spec_mem_wdata;
            c_rvfi_mem_wmask <= rvfi_mem_wmask;
            c_spec_mem_wmask <= spec_mem_wmask;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
            if (tmo_cnt == TMO_LAST) fail_code <= 8'h80;
          end
        end
        S_CAPT:  fail_code <= cmp_code;
        default: ;
      endcase
    end
  end

  assign busy = (state == S_ARMED) || (state == S_CAPT);
  assign pass = state == S_PASS;
  assign fail = state == S_FAIL;
  assign done = pass || fail;

endmodule
